// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } kp_state_t;

  // One-hot active-low row drive for row index r.
  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Row-slot timer: tick is high for one clk when the slot counter reaches SCAN_DIV-1.
module scan_tick #(
  parameter int SCAN_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with ghost rejection and press/release debounce.
// Optional KEYPAD_SHIFT_EN adds a 32-bit shift register of accepted key codes.
//
// state      | meaning
// IDLE       | no key held, waiting for a single-key frame
// DB_PRESS   | counting consecutive frames of the pending key
// PRESSED    | key accepted, key_held high
// DB_RELEASE | counting consecutive frames without the accepted key
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] COL_N,
  output logic [NUM_ROWS-1:0] ROW_N,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_held
`ifdef KEYPAD_SHIFT_EN
  ,
  output logic [31:0]         digits
`endif
);

  localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_SCANS);
  localparam int SNAP_W = NUM_ROWS * NUM_COLS;

  logic [NUM_COLS-1:0] col_s1, col_s2;
  logic                tick;
  logic [1:0]          row_idx;
  logic [SNAP_W-1:0]   snapshot;
  logic                frame_done;

  logic                cand_valid;
  logic [KEY_W-1:0]    cand_code;
  logic [4:0]          ones;

  kp_state_t           state;
  logic [KEY_W-1:0]    pending;
  logic [3:0]          stable_cnt;
  logic [3:0]          cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= COL_N;
      col_s2 <= col_s1;
    end
  end

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Snapshot bit index 4*row+col equals the key code of that position.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx    <= 2'd0;
      ROW_N      <= 4'b1110;
      snapshot   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        snapshot[{row_idx, 2'b00} +: NUM_COLS] <= ~col_s2;
        row_idx    <= row_idx + 2'd1;
        ROW_N      <= row_drive(row_idx + 2'd1);
        frame_done <= (row_idx == 2'd3);
      end
    end
  end

  always_comb begin
    ones      = 5'd0;
    cand_code = '0;
    for (int i = 0; i < SNAP_W; i++) begin
      if (snapshot[i]) begin
        ones      = ones + 5'd1;
        cand_code = KEY_W'(i);
      end
    end
    cand_valid = (ones == 5'd1);
  end

  assign cnt_inc = stable_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      stable_cnt <= 4'd0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        case (state)
          IDLE: begin
            if (cand_valid) begin
              pending <= cand_code;
              if (DB_CNT <= 4'd1) begin
                key_valid  <= 1'b1;
                key_code   <= cand_code;
                key_held   <= 1'b1;
                stable_cnt <= 4'd0;
                state      <= PRESSED;
              end else begin
                stable_cnt <= 4'd1;
                state      <= DB_PRESS;
              end
            end
          end
          DB_PRESS: begin
            if (!cand_valid) begin
              stable_cnt <= 4'd0;
              state      <= IDLE;
            end else if (cand_code != pending) begin
              pending    <= cand_code;
              stable_cnt <= 4'd1;
            end else if (cnt_inc >= DB_CNT) begin
              key_valid  <= 1'b1;
              key_code   <= pending;
              key_held   <= 1'b1;
              stable_cnt <= 4'd0;
              state      <= PRESSED;
            end else begin
              stable_cnt <= cnt_inc;
            end
          end
          PRESSED: begin
            // "none" counts as not matching, so an empty frame starts release.
            if (!cand_valid || cand_code != key_code) begin
              if (DB_CNT <= 4'd1) begin
                key_held   <= 1'b0;
                stable_cnt <= 4'd0;
                state      <= IDLE;
              end else begin
                stable_cnt <= 4'd1;
                state      <= DB_RELEASE;
              end
            end
          end
          DB_RELEASE: begin
            if (cand_valid && cand_code == key_code) begin
              stable_cnt <= 4'd0;
              state      <= PRESSED;
            end else if (cnt_inc >= DB_CNT) begin
              key_held   <= 1'b0;
              stable_cnt <= 4'd0;
              state      <= IDLE;
            end else begin
              stable_cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef KEYPAD_SHIFT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= 32'd0;
    end else if (key_valid) begin
      digits <= {digits[27:0], key_code};
    end
  end
`endif

endmodule
